// File: rtl/move_input.sv
// move_input: conditions the four raw direction buttons into the committed
// one-hot movement direction for the snake move stage.
//   btn -> 2-FF synchronizer -> counter debounce -> rising-edge detect ->
//   reversal / same-direction filter -> held request -> commit on tick.
// Optional build macro MOVE_INPUT_QUEUE2_EN turns the single held request
// into a 2-entry FIFO, so two quick turns are replayed on consecutive ticks.
// Bit encoding of btn/movement: [0]=up [1]=down [2]=left [3]=right.
module move_input #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 19,
   parameter logic [3:0]  INIT_DIR        = 4'b1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn,
   input  logic       tick,
   input  logic       enable,
   output logic [3:0] movement,
   output logic       dir_changed,
   output logic       pending
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Opposite direction: up<->down, left<->right.
   function automatic logic [3:0] opp_dir(input logic [3:0] d);
      return {d[2], d[3], d[0], d[1]};
   endfunction

   // A direction is acceptable against r if it is neither r nor its reverse.
   function automatic logic is_valid(input logic [3:0] d, input logic [3:0] r);
      return (d & (r | opp_dir(r))) == 4'b0000;
   endfunction

   // Highest-priority (lowest index) press that is valid against r; 0 if none.
   function automatic logic [3:0] pick(input logic [3:0] p, input logic [3:0] r);
      logic [3:0] c;
      c = p & ~(r | opp_dir(r));
      return c & (~c + 4'd1);
   endfunction

   logic [3:0]       sync1_q, sync2_q;
   logic [3:0]       deb_q, deb_prev_q;
   logic [CNT_W-1:0] dbc_q [4];
   logic [3:0]       press_s;

   logic [3:0]       movement_q, mov_d;
   logic             chg_q, chg_d;
   logic             pending_q, pend_d;
   logic [3:0]       sel_s;

   // Two-flop synchronizer for the asynchronous buttons.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 4'b0000;
         sync2_q <= 4'b0000;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
      end
   end

   // Per-bit debounce: level flips only after DEBOUNCE_CYCLES mismatching samples.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_q <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            dbc_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               dbc_q[i] <= '0;
            end else if (dbc_q[i] == CNT_LAST) begin
               deb_q[i] <= ~deb_q[i];
               dbc_q[i] <= '0;
            end else begin
               dbc_q[i] <= dbc_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   // Edge register; it tracks the debounced level even while disabled so a
   // button already held when enable rises never produces a press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_prev_q <= 4'b0000;
      end else begin
         deb_prev_q <= deb_q;
      end
   end

   assign press_s = deb_q & ~deb_prev_q;

`ifdef MOVE_INPUT_QUEUE2_EN

   logic [3:0] q0_q, q1_q, q0_d, q1_d;
   logic [1:0] qcnt_q, qcnt_d;
   logic [3:0] ref_s;

   // FIFO next state: pop on tick first, then validate the press against the new tail.
   always_comb begin
      mov_d  = movement_q;
      chg_d  = 1'b0;
      q0_d   = q0_q;
      q1_d   = q1_q;
      qcnt_d = qcnt_q;
      ref_s  = movement_q;
      sel_s  = 4'b0000;
      if (!enable) begin
         qcnt_d = 2'd0;
      end else begin
         if (tick && (qcnt_q != 2'd0)) begin
            mov_d  = q0_q;
            q0_d   = q1_q;
            qcnt_d = qcnt_q - 2'd1;
            chg_d  = 1'b1;
         end else begin
            qcnt_d = qcnt_q;
         end
         case (qcnt_d)
            2'd0:    ref_s = mov_d;
            2'd1:    ref_s = q0_d;
            default: ref_s = q1_d;
         endcase
         sel_s = pick(press_s, ref_s);
         if (sel_s != 4'b0000) begin
            if (tick && (qcnt_q == 2'd0)) begin
               mov_d = sel_s;
               chg_d = 1'b1;
            end else if (qcnt_d == 2'd0) begin
               q0_d   = sel_s;
               qcnt_d = 2'd1;
            end else if (qcnt_d == 2'd1) begin
               q1_d   = sel_s;
               qcnt_d = 2'd2;
            end else if (is_valid(sel_s, q0_d)) begin
               q1_d = sel_s;
            end else begin
               qcnt_d = 2'd2;
            end
         end else begin
            sel_s = 4'b0000;
         end
      end
      pend_d = (qcnt_d != 2'd0);
   end

   // Direction state registers (FIFO build).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         movement_q <= INIT_DIR;
         chg_q      <= 1'b0;
         pending_q  <= 1'b0;
         q0_q       <= 4'b0000;
         q1_q       <= 4'b0000;
         qcnt_q     <= 2'd0;
      end else begin
         movement_q <= mov_d;
         chg_q      <= chg_d;
         pending_q  <= pend_d;
         q0_q       <= q0_d;
         q1_q       <= q1_d;
         qcnt_q     <= qcnt_d;
      end
   end

`else

   logic [3:0] held_q, held_d;

   // Single held request: accept, overwrite, or commit on the step tick.
   always_comb begin
      mov_d  = movement_q;
      held_d = held_q;
      pend_d = pending_q;
      chg_d  = 1'b0;
      sel_s  = 4'b0000;
      if (!enable) begin
         pend_d = 1'b0;
      end else if (tick && pending_q) begin
         mov_d = held_q;
         chg_d = 1'b1;
         sel_s = pick(press_s, held_q);
         if (sel_s != 4'b0000) begin
            held_d = sel_s;
            pend_d = 1'b1;
         end else begin
            pend_d = 1'b0;
         end
      end else if (tick) begin
         sel_s = pick(press_s, movement_q);
         if (sel_s != 4'b0000) begin
            mov_d = sel_s;
            chg_d = 1'b1;
         end else begin
            chg_d = 1'b0;
         end
      end else if (pending_q) begin
         sel_s = pick(press_s, held_q);
         if ((sel_s != 4'b0000) && is_valid(sel_s, movement_q)) begin
            held_d = sel_s;
         end else begin
            held_d = held_q;
         end
      end else begin
         sel_s = pick(press_s, movement_q);
         if (sel_s != 4'b0000) begin
            held_d = sel_s;
            pend_d = 1'b1;
         end else begin
            pend_d = 1'b0;
         end
      end
   end

   // Direction state registers (single held request build).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         movement_q <= INIT_DIR;
         chg_q      <= 1'b0;
         pending_q  <= 1'b0;
         held_q     <= 4'b0000;
      end else begin
         movement_q <= mov_d;
         chg_q      <= chg_d;
         pending_q  <= pend_d;
         held_q     <= held_d;
      end
   end

`endif

   assign movement    = movement_q;
   assign dir_changed = chg_q;
   assign pending     = pending_q;

endmodule
